// File: rtl/regfile_seq_pkg.sv
// Shared types for the regfile command sequencer: ALU op codes, FSM states and the queued command.
package regfile_seq_pkg;

  localparam int SEQ_AW   = 5;
  localparam int SEQ_IMMW = 15;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_LT  = 4'b0111;
  localparam logic [3:0] ALUOP_SRL = 4'b1000;
  localparam logic [3:0] ALUOP_SLL = 4'b1001;
  localparam logic [3:0] ALUOP_SRA = 4'b1010;
  localparam logic [3:0] ALUOP_XOR = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                imm;
    logic [SEQ_AW-1:0]   rd;
    logic [SEQ_AW-1:0]   rs1;
    logic [SEQ_AW-1:0]   rs2;
    logic [3:0]          op;
    logic [SEQ_IMMW-1:0] value;
  } seq_cmd_t;

endpackage

// File: rtl/regfile_sequencer_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from the registered occupancy count.
module rfseq_cmd_fifo
  import regfile_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  seq_cmd_t wdata_i,
  input  logic     pop_i,
  output seq_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  seq_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Valid/ready command sequencer stepping each queued command through READ -> EXEC -> WB.
// Optional feature macro: RFSEQ_PERF_CNT_EN builds the 16-bit completed-command counter.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_imm,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [3:0]            cmd_op,
  input  logic [14:0]           cmd_value,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_we,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] done_rd,
  output logic [DATA_WIDTH-1:0] done_data,
  output logic [15:0]           op_count
);

  seq_state_t            state_q, state_d;
  seq_cmd_t              cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  seq_cmd_t              cmd_in, head;
  logic                  fifo_full, fifo_empty, pop;
  logic [DATA_WIDTH-1:0] imm_ext, wb_val;

  assign cmd_in = '{imm:   cmd_imm,
                    rd:    SEQ_AW'(cmd_rd),
                    rs1:   SEQ_AW'(cmd_rs1),
                    rs2:   SEQ_AW'(cmd_rs2),
                    op:    cmd_op,
                    value: cmd_value};

  rfseq_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign imm_ext   = {{(DATA_WIDTH-SEQ_IMMW){cmd_q.value[SEQ_IMMW-1]}}, cmd_q.value};
  assign wb_val    = cmd_q.imm ? imm_ext : result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
    end
  end

  // Head is only popped from IDLE, so WB always retires before the next READ.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        cmd_d   = head;
        state_d = head.imm ? ST_WB : ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    done      = 1'b0;
    done_rd   = '0;
    done_data = '0;
    case (state_q)
      ST_READ: begin
        rf_raddr1 = ADDR_WIDTH'(cmd_q.rs1);
        rf_raddr2 = ADDR_WIDTH'(cmd_q.rs2);
      end
      ST_EXEC: begin
        alu_op = cmd_q.op;
        alu_a  = rf_rdata1;
        alu_b  = rf_rdata2;
      end
      ST_WB: begin
        rf_waddr  = ADDR_WIDTH'(cmd_q.rd);
        rf_wdata  = wb_val;
        rf_we     = (cmd_q.rd != '0);
        done      = 1'b1;
        done_rd   = ADDR_WIDTH'(cmd_q.rd);
        done_data = wb_val;
      end
      default: ;
    endcase
  end

`ifdef RFSEQ_PERF_CNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk) begin
    if (rst)       op_count_q <= '0;
    else if (done) op_count_q <= op_count_q + 16'd1;
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule
